// File: rtl/alien_formation_mover_pkg.sv
// alien_pkg: motion encoding shared with the renderer and the mover state enum.
package alien_pkg;
  localparam logic [1:0] MOTION_NONE  = 2'd0;
  localparam logic [1:0] MOTION_LEFT  = 2'd1;
  localparam logic [1:0] MOTION_RIGHT = 2'd2;
  localparam logic [1:0] MOTION_DOWN  = 2'd3;
  typedef enum logic [1:0] {ST_IDLE, ST_MARCH, ST_DESCEND, ST_LANDED} mover_state_t;
endpackage

// File: rtl/alien_formation_mover_if.sv
// alien_formation_mover_if: game-side controls in, formation motion/position out.
interface alien_formation_mover_if #(
  parameter int X_W   = 10,
  parameter int Y_W   = 9,
  parameter int CNT_W = 6
);
  logic             enable;
  logic             run;
  logic             wave_restart;
  logic             canLeft;
  logic             canRight;
  logic [CNT_W-1:0] alive_count;
  logic [1:0]       Motion;
  logic [X_W-1:0]   pos_x;
  logic [Y_W-1:0]   pos_y;
  logic             dir_right;
  logic             landed;
  logic             step;
  modport master (
    output enable, run, wave_restart, canLeft, canRight, alive_count,
    input  Motion, pos_x, pos_y, dir_right, landed, step
  );
  modport slave (
    input  enable, run, wave_restart, canLeft, canRight, alive_count,
    output Motion, pos_x, pos_y, dir_right, landed, step
  );
endinterface

// File: rtl/alien_formation_mover_step_rate_divider.sv
// step_rate_divider: turns game ticks into step events, period shrinking with fewer aliens.
module step_rate_divider #(
  parameter int CNT_W            = 6,
  parameter int PER_W            = 8,
  parameter int MIN_PERIOD       = 2,
  parameter int PERIOD_PER_ALIVE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             run,
  input  logic             wave_restart,
  input  logic             frozen,
  input  logic [CNT_W-1:0] alive_count,
  output logic             step_ev
);
  localparam int PMAX = 2**PER_W - 1;
  logic [31:0]      raw;
  logic [PER_W-1:0] period, tick_q, tick_d;
  logic             active;
  assign raw     = 32'(MIN_PERIOD) + 32'(alive_count) * 32'(PERIOD_PER_ALIVE);
  assign period  = (raw > 32'(PMAX)) ? PER_W'(PMAX) : (raw == '0) ? PER_W'(1) : raw[PER_W-1:0];
  assign active  = enable && run && (alive_count != '0) && !frozen;
  // >= rather than == so a period that shrinks mid-count fires on the next tick
  assign step_ev = active && (tick_q >= period - PER_W'(1));
  always_comb begin
    tick_d = (wave_restart || step_ev) ? '0 : active ? tick_q + PER_W'(1) : tick_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) tick_q <= '0;
    else        tick_q <= tick_d;
  end
endmodule

// File: rtl/alien_formation_mover.sv
// alien_formation_mover: zig-zag formation FSM with saturating origin, multi-row
// descents, landing detection and wave restart.
module alien_formation_mover
  import alien_pkg::*;
#(
  parameter int X_W              = 10,
  parameter int Y_W              = 9,
  parameter int CNT_W            = 6,
  parameter int PER_W            = 8,
  parameter int X_START          = 0,
  parameter int Y_START          = 32,
  parameter int Y_LIMIT          = 400,
  parameter int STEP_X           = 2,
  parameter int STEP_Y           = 8,
  parameter int DOWN_STEPS       = 1,
  parameter int MIN_PERIOD       = 2,
  parameter int PERIOD_PER_ALIVE = 1
) (
  input logic                  clk,
  input logic                  reset,
  alien_formation_mover_if.slave bus
);
  localparam int DW = $clog2(DOWN_STEPS + 1);
  localparam logic [X_W-1:0] SX   = X_W'(STEP_X);
  localparam logic [X_W-1:0] XMAX = '1;
  mover_state_t   state_q, state_d;
  logic [X_W-1:0] pos_x_q, pos_x_d, x_left, x_right;
  logic [Y_W-1:0] pos_y_q, pos_y_d;
  logic [Y_W:0]   y_sum;
  logic [1:0]     motion_q, motion_d;
  logic [DW-1:0]  down_q, down_d;
  logic step_q, step_d, dir_q, dir_d, landed_q, landed_d;
  logic step_ev, frozen, fwd_ok, rev_ok, marching, descending, more_down;
  logic do_down, do_move, mv_dir, land;
  assign frozen = (state_q == ST_LANDED);
  step_rate_divider #(
    .CNT_W(CNT_W), .PER_W(PER_W), .MIN_PERIOD(MIN_PERIOD), .PERIOD_PER_ALIVE(PERIOD_PER_ALIVE)
  ) u_div (
    .clk(clk), .reset(reset), .enable(bus.enable), .run(bus.run),
    .wave_restart(bus.wave_restart), .frozen(frozen), .alive_count(bus.alive_count),
    .step_ev(step_ev)
  );
  assign x_right    = (pos_x_q > XMAX - SX) ? XMAX : pos_x_q + SX;
  assign x_left     = (pos_x_q < SX) ? '0 : pos_x_q - SX;
  assign y_sum      = {1'b0, pos_y_q} + (Y_W+1)'(STEP_Y);
  assign land       = (y_sum >= (Y_W+1)'(Y_LIMIT));
  assign fwd_ok     = dir_q ? bus.canRight : bus.canLeft;
  assign rev_ok     = dir_q ? bus.canLeft : bus.canRight;
  assign marching   = step_ev && (state_q == ST_MARCH);
  assign descending = step_ev && (state_q == ST_DESCEND);
  assign more_down  = (down_q < DW'(DOWN_STEPS));
  assign do_down    = (marching && !fwd_ok) || (descending && more_down);
  assign do_move    = (marching && fwd_ok) || (descending && !more_down && (fwd_ok || rev_ok));
  // After a descent the formation prefers its new direction but reverses if that side is blocked
  assign mv_dir     = (state_q == ST_MARCH || fwd_ok) ? dir_q : !dir_q;
  assign step_d     = (motion_d != MOTION_NONE);
  always_comb begin
    state_d  = state_q;
    pos_x_d  = pos_x_q;
    pos_y_d  = pos_y_q;
    dir_d    = dir_q;
    landed_d = landed_q;
    down_d   = down_q;
    motion_d = MOTION_NONE;
    if (bus.wave_restart) begin
      state_d  = ST_IDLE;
      pos_x_d  = X_W'(X_START);
      pos_y_d  = Y_W'(Y_START);
      dir_d    = 1'b1;
      landed_d = 1'b0;
      down_d   = '0;
    end else if (state_q == ST_IDLE && bus.run && bus.alive_count != '0) begin
      state_d = ST_MARCH;
    end else if (do_down) begin
      motion_d = MOTION_DOWN;
      pos_y_d  = land ? Y_W'(Y_LIMIT) : y_sum[Y_W-1:0];
      landed_d = land;
      state_d  = land ? ST_LANDED : ST_DESCEND;
      down_d   = marching ? DW'(1) : down_q + DW'(1);
      dir_d    = marching ? !dir_q : dir_q;
    end else if (do_move) begin
      motion_d = mv_dir ? MOTION_RIGHT : MOTION_LEFT;
      pos_x_d  = mv_dir ? x_right : x_left;
      dir_d    = mv_dir;
      state_d  = ST_MARCH;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      pos_x_q  <= X_W'(X_START);
      pos_y_q  <= Y_W'(Y_START);
      dir_q    <= 1'b1;
      landed_q <= 1'b0;
      down_q   <= '0;
      motion_q <= MOTION_NONE;
      step_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pos_x_q  <= pos_x_d;
      pos_y_q  <= pos_y_d;
      dir_q    <= dir_d;
      landed_q <= landed_d;
      down_q   <= down_d;
      motion_q <= motion_d;
      step_q   <= step_d;
    end
  end
  assign bus.Motion    = motion_q;
  assign bus.step      = step_q;
  assign bus.pos_x     = pos_x_q;
  assign bus.pos_y     = pos_y_q;
  assign bus.dir_right = dir_q;
  assign bus.landed    = landed_q;
endmodule

// File: tb/tb_alien_formation_mover.sv
// tb_alien_formation_mover: random stimulus against a behavioural formation model,
// plus directed pacing, frozen-count and asynchronous reset checks.
module tb_alien_formation_mover;
  localparam int X_W = 10, Y_W = 9, CNT_W = 6;
  localparam int X0 = 0, Y0 = 32, YL = 100, SX = 2, SY = 8, DS = 2, MINP = 2, PPA = 1;
  localparam int XMAX = 2**X_W - 1, PMAX = 255;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0, failures = 0;
  int m_x, m_y, m_ticks, m_downs, m_motion;
  bit m_dir, m_landed, m_started, m_desc;
  alien_formation_mover_if #(.X_W(X_W), .Y_W(Y_W), .CNT_W(CNT_W)) bus ();
  alien_formation_mover #(.X_W(X_W), .Y_W(Y_W), .CNT_W(CNT_W), .Y_START(Y0), .Y_LIMIT(YL),
                          .DOWN_STEPS(DS)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    chk("motion", 32'(bus.Motion), 32'(m_motion));
    chk("step", 32'(bus.step), 32'(m_motion != 0));
    chk("pos_x", 32'(bus.pos_x), 32'(m_x));
    chk("pos_y", 32'(bus.pos_y), 32'(m_y));
    chk("dir_right", 32'(bus.dir_right), 32'(m_dir));
    chk("landed", 32'(bus.landed), 32'(m_landed));
  endtask

  task automatic model_reset();
    m_x = X0; m_y = Y0; m_ticks = 0; m_downs = 0; m_motion = 0;
    m_dir = 1; m_landed = 0; m_started = 0; m_desc = 0;
  endtask

  task automatic go_down();
    m_y += SY; m_motion = 3; m_downs++; m_desc = 1;
    if (m_y >= YL) begin m_y = YL; m_landed = 1; end
  endtask

  task automatic move(input bit d);
    m_motion = d ? 2 : 1;
    m_x = d ? ((m_x + SX > XMAX) ? XMAX : m_x + SX) : ((m_x < SX) ? 0 : m_x - SX);
    m_dir = d; m_desc = 0;
  endtask

  // Advance the model across one clock edge using the inputs currently driven
  task automatic model_clock();
    int alive, period;
    bit gated, fire, fwd, rev;
    alive = int'(bus.alive_count);
    m_motion = 0;
    if (bus.wave_restart) begin
      model_reset();
      return;
    end
    period = MINP + alive * PPA;
    if (period > PMAX) period = PMAX;
    if (period == 0) period = 1;
    gated = bus.enable && bus.run && alive != 0 && !m_landed;
    fire = gated && (m_ticks >= period - 1);
    m_ticks = fire ? 0 : gated ? m_ticks + 1 : m_ticks;
    fwd = m_dir ? bus.canRight : bus.canLeft;
    rev = m_dir ? bus.canLeft : bus.canRight;
    if (!(bus.run && alive != 0 && !m_landed)) return;
    if (!m_started) m_started = 1;
    else if (fire) begin
      if (m_desc && m_downs < DS) go_down();
      else if (!m_desc && !fwd) begin m_dir = !m_dir; m_downs = 0; go_down(); end
      else if (fwd) move(m_dir);
      else if (rev) move(!m_dir);
    end
  endtask

  task automatic drive(input bit en, input bit rn, input bit rs, input bit cl, input bit cr,
                       input int alive);
    bus.enable = en; bus.run = rn; bus.wave_restart = rs;
    bus.canLeft = cl; bus.canRight = cr; bus.alive_count = CNT_W'(alive);
  endtask

  task automatic drive_random(input bit allow_rs);
    drive($urandom_range(0, 3) != 0, $urandom_range(0, 19) != 0,
          allow_rs && $urandom_range(0, 399) == 0,
          $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0,
          ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(1, 4)));
  endtask

  task automatic tick_and_check();
    model_clock();
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    bit seen;
    drive(0, 0, 0, 0, 0, 0);
    model_reset();
    #12 check_outputs();
    @(negedge clk) reset = 1'b1;
    // pacing: four aliens gives a step every sixth tick
    repeat (20) begin drive(1, 1, 0, 1, 1, 4); tick_and_check(); end
    // no aliens: formation and counter frozen
    repeat (100) begin drive(1, 1, 0, 1, 1, 0); tick_and_check(); end
    repeat (4) begin drive(1, 1, 0, 1, 1, 1); tick_and_check(); end
    repeat (1500) begin drive_random(1'b1); tick_and_check(); end
    repeat (1500) begin drive_random(1'b0); tick_and_check(); end
    drive(0, 0, 1, 0, 0, 1); tick_and_check();
    seen = 0;
    for (int i = 0; i < 500 && !seen; i++) begin
      drive(1, 1, 0, 1, 1, 1);
      tick_and_check();
      seen = (m_motion != 0);
    end
    chk("step_wait", 32'(seen), 32'd1);
    #2 reset = 1'b0;
    model_reset();
    #1 check_outputs();
    @(negedge clk) reset = 1'b1;
    repeat (200) begin drive_random(1'b1); tick_and_check(); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
